// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the sram_ctrl SRAM initiator: FSM states,
// default geometry/timing, and the strobe levels driven in each state.
package sram_ctrl_pkg;

  localparam int DEF_AW       = 8;
  localparam int DEF_DW       = 8;
  localparam int DEF_WR_PULSE = 1;
  localparam int DEF_RD_WAIT  = 2;

  localparam logic CS_IDLE = 1'b0;
  localparam logic WR_IDLE = 1'b0;
  localparam logic RD_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE, SETUP, WSTROBE, WHOLD, RSTROBE, RCAP, VSTROBE, VCHK
  } state_t;

  typedef struct packed {
    logic cs;
    logic wr;
    logic rd;
  } strobe_t;

  // Pin levels held for the whole time the FSM sits in state s.
  function automatic strobe_t strobe_of(state_t s);
    strobe_t st;
    st = '{cs: CS_IDLE, wr: WR_IDLE, rd: RD_IDLE};
    case (s)
      WSTROBE:                  st = '{cs: 1'b1, wr: 1'b1, rd: 1'b1};
      RSTROBE, VSTROBE:         st = '{cs: 1'b1, wr: 1'b0, rd: 1'b0};
      SETUP, WHOLD, RCAP, VCHK: st = '{cs: 1'b1, wr: 1'b0, rd: 1'b1};
      default:                  ;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-beat valid/ready host to asynchronous SRAM initiator (setup, strobe, hold).
// Define SRAM_CTRL_VERIFY_EN to add a read-back check after every write (vfy_err).
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int WR_PULSE = DEF_WR_PULSE,
  parameter int RD_WAIT  = DEF_RD_WAIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          sram_cs,
  output logic          sram_wr,
  output logic          sram_rd,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
`ifdef SRAM_CTRL_VERIFY_EN
  ,
  output logic          vfy_err
`endif
);

  localparam int PMAX = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int CW   = $clog2(PMAX + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_PULSE);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT);

  state_t        state;
  logic          we;
  logic [CW-1:0] cnt;

  assign req_ready = (state == IDLE) && !rst;

`ifdef SRAM_CTRL_VERIFY_EN
  logic [DW-1:0] vfy_data;
  assign vfy_err = (state == VCHK) && (vfy_data != sram_din);
`endif

  // Strobes are registered alongside the state, so every pin changes only on
  // the edge that enters a new state and never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register, including the datapath copies, is reset so the
      // SRAM pins and the response bus come up at defined levels.
      state     <= IDLE;
      we        <= 1'b0;
      cnt       <= '0;
      sram_addr <= '0;
      sram_din  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      {sram_cs, sram_wr, sram_rd} <= strobe_of(IDLE);
`ifdef SRAM_CTRL_VERIFY_EN
      vfy_data  <= '0;
`endif
    end else begin
      // NOTE: non-blocking throughout; every right-hand side reads the value
      // from before this edge.
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          sram_addr <= req_addr;
          sram_din  <= req_wdata;
          we        <= req_we;
          state     <= SETUP;
          {sram_cs, sram_wr, sram_rd} <= strobe_of(SETUP);
        end
        SETUP: begin
          cnt   <= we ? WR_LOAD : RD_LOAD;
          state <= we ? WSTROBE : RSTROBE;
          {sram_cs, sram_wr, sram_rd} <= strobe_of(we ? WSTROBE : RSTROBE);
        end
        WSTROBE: if (cnt == CNT_ONE) begin
          state <= WHOLD;
          {sram_cs, sram_wr, sram_rd} <= strobe_of(WHOLD);
        end else begin
          cnt <= cnt - CNT_ONE;
        end
        WHOLD: begin
`ifdef SRAM_CTRL_VERIFY_EN
          cnt   <= RD_LOAD;
          state <= VSTROBE;
          {sram_cs, sram_wr, sram_rd} <= strobe_of(VSTROBE);
`else
          state <= IDLE;
          {sram_cs, sram_wr, sram_rd} <= strobe_of(IDLE);
`endif
        end
        RSTROBE: if (cnt == CNT_ONE) begin
          rsp_rdata <= sram_dout;
          rsp_valid <= 1'b1;
          state     <= RCAP;
          {sram_cs, sram_wr, sram_rd} <= strobe_of(RCAP);
        end else begin
          cnt <= cnt - CNT_ONE;
        end
`ifdef SRAM_CTRL_VERIFY_EN
        VSTROBE: if (cnt == CNT_ONE) begin
          vfy_data <= sram_dout;
          state    <= VCHK;
          {sram_cs, sram_wr, sram_rd} <= strobe_of(VCHK);
        end else begin
          cnt <= cnt - CNT_ONE;
        end
`endif
        default: begin
          state <= IDLE;
          {sram_cs, sram_wr, sram_rd} <= strobe_of(IDLE);
        end
      endcase
    end
  end

endmodule
